// File: rtl/sd_pkg.sv
// Shared definitions for the SD CMD-line blocks: frame constants, FSM encoding and the CRC7 step.
package sd_pkg;

    localparam int unsigned FRAME_LEN = 48;
    localparam logic [5:0]  R3_IDX    = 6'h3F;
    localparam logic [6:0]  R3_CRC    = 7'h7F;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RECV = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_NCR  = 3'd3;
    localparam logic [2:0] S_SEND = 3'd4;

    // One serial step of CRC7 (x^7 + x^3 + 1), MSB first.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = crc[6] ^ b;
        return {crc[5:0], fb} ^ {3'b000, fb, 3'b000};
    endfunction

endpackage

// File: rtl/sd_edge_sync.sv
// Synchronises sdclk and sdcmd into the clk domain and derives sdclk rise/fall pulses.
module sd_edge_sync #(
    parameter int unsigned SYNC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sdclk,
    input  logic i_sdcmd,
    output logic o_rise_c,
    output logic o_fall_c,
    output logic o_cmd
);

    logic [SYNC-1:0] r_clk_sync;
    logic [SYNC-1:0] r_cmd_sync;
    logic            r_clk_prev;

    // Both lines share the same depth so the sampled CMD bit stays aligned with the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync <= '0;
            r_cmd_sync <= '1;
            r_clk_prev <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC-2:0], i_sdclk};
            r_cmd_sync <= {r_cmd_sync[SYNC-2:0], i_sdcmd};
            r_clk_prev <= r_clk_sync[SYNC-1];
        end
    end

    assign o_rise_c = r_clk_sync[SYNC-1] & ~r_clk_prev;
    assign o_fall_c = ~r_clk_sync[SYNC-1] & r_clk_prev;
    assign o_cmd    = r_cmd_sync[SYNC-1];

endmodule

// File: rtl/sdcmd_card.sv
// Card-side SD CMD-line responder: receives and checks 48-bit host commands, then
// serialises the emulation logic's 48-bit response after NCR sdclk cycles.
module sdcmd_card
    import sd_pkg::*;
#(
    parameter int unsigned NCR        = 2,
    parameter int unsigned WAIT_EDGES = 64,
    parameter int unsigned SYNC       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sdclk,
    inout  wire         sdcmd,
    output logic        cmd_valid,
    output logic [5:0]  cmd_idx,
    output logic [31:0] cmd_arg,
    output logic        cmd_crcerr,
    output logic        busy,
    input  logic        resp_start,
    input  logic        resp_drop,
    input  logic [5:0]  resp_cmd,
    input  logic [31:0] resp_arg,
    input  logic        resp_nocrc,
    output logic        resp_done
);

    localparam int unsigned WAIT_W = $clog2(WAIT_EDGES + 1);

    logic [2:0]           r_state,  w_state;
    logic [5:0]           r_cnt,    w_cnt;
    logic [6:0]           r_crc,    w_crc;
    logic [FRAME_LEN-1:0] r_shift,  w_shift;
    logic [FRAME_LEN-1:0] r_resp,   w_resp;
    logic [WAIT_W-1:0]    r_wait,   w_wait;
    logic                 r_fin,    w_fin;
    logic                 r_oe,     w_oe;
    logic                 r_out,    w_out;
    logic                 r_tail,   w_tail;
    logic                 r_cmd_valid, w_cmd_valid;
    logic [5:0]           r_cmd_idx,   w_cmd_idx;
    logic [31:0]          r_cmd_arg,   w_cmd_arg;
    logic                 r_cmd_crcerr, w_cmd_crcerr;
    logic                 r_busy;
    logic                 r_resp_done, w_resp_done;

    logic                 w_line_in;
    logic                 w_rise;
    logic                 w_fall;
    logic                 w_cmd;
    logic [5:0]           w_resp_idx;
    logic [39:0]          w_resp_msg;
    logic [6:0]           w_resp_crc;
    logic [FRAME_LEN-1:0] w_resp_frame;

    // Our own drive is never sampled back; while driving the line reads as idle-high.
    assign w_line_in = r_oe ? 1'b1 : sdcmd;
    assign sdcmd     = r_oe ? r_out : 1'bz;

    sd_edge_sync #(.SYNC(SYNC)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .i_sdclk  (sdclk),
        .i_sdcmd  (w_line_in),
        .o_rise_c (w_rise),
        .o_fall_c (w_fall),
        .o_cmd    (w_cmd)
    );

    // Response frame assembly; R3 replaces index and CRC with all-ones.
    always_comb begin
        w_resp_idx = resp_nocrc ? R3_IDX : resp_cmd;
        w_resp_msg = {2'b00, w_resp_idx, resp_arg};
        w_resp_crc = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            w_resp_crc = crc7_step(w_resp_crc, w_resp_msg[i]);
        end
        w_resp_frame = {w_resp_msg, (resp_nocrc ? R3_CRC : w_resp_crc), 1'b1};
    end

    always_comb begin
        w_state      = r_state;
        w_cnt        = r_cnt;
        w_crc        = r_crc;
        w_shift      = r_shift;
        w_resp       = r_resp;
        w_wait       = r_wait;
        w_fin        = r_fin;
        w_oe         = r_oe;
        w_out        = r_out;
        w_tail       = r_tail;
        w_cmd_valid  = 1'b0;
        w_cmd_idx    = r_cmd_idx;
        w_cmd_arg    = r_cmd_arg;
        w_cmd_crcerr = r_cmd_crcerr;
        w_resp_done  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_rise && !w_cmd) begin
                    w_state = S_RECV;
                    w_cnt   = 6'd46;
                    w_crc   = crc7_step(7'h00, 1'b0);
                    w_shift = '0;
                    w_fin   = 1'b0;
                end
            end
            S_RECV: begin
                if (r_fin) begin
                    w_cmd_valid  = 1'b1;
                    w_cmd_idx    = r_shift[45:40];
                    w_cmd_arg    = r_shift[39:8];
                    w_cmd_crcerr = (r_crc != r_shift[7:1]) | ~r_shift[0] | ~r_shift[46] | r_shift[47];
                    w_fin        = 1'b0;
                    w_wait       = '0;
                    w_state      = S_WAIT;
                end else if (w_rise) begin
                    w_shift = {r_shift[FRAME_LEN-2:0], w_cmd};
                    if (r_cnt >= 6'd8) begin
                        w_crc = crc7_step(r_crc, w_cmd);
                    end
                    if (r_cnt == 6'd0) begin
                        w_fin = 1'b1;
                    end else begin
                        w_cnt = r_cnt - 6'd1;
                    end
                end
            end
            S_WAIT: begin
                if (resp_drop) begin
                    w_state = S_IDLE;
                end else if (resp_start) begin
                    w_resp  = w_resp_frame;
                    w_cnt   = 6'(NCR - 1);
                    w_state = S_NCR;
                end else if (w_rise) begin
                    if (r_wait == WAIT_W'(WAIT_EDGES - 1)) begin
                        w_state = S_IDLE;
                    end else begin
                        w_wait = r_wait + WAIT_W'(1);
                    end
                end
            end
            S_NCR: begin
                if (w_fall) begin
                    if (r_cnt == 6'd0) begin
                        w_oe    = 1'b1;
                        w_out   = r_resp[FRAME_LEN-1];
                        w_cnt   = 6'd47;
                        w_tail  = 1'b0;
                        w_state = S_SEND;
                    end else begin
                        w_cnt = r_cnt - 6'd1;
                    end
                end
            end
            S_SEND: begin
                // After bit 0 one extra high period emulates the pull-up before release.
                if (w_fall) begin
                    if (r_tail) begin
                        w_oe        = 1'b0;
                        w_out       = 1'b1;
                        w_tail      = 1'b0;
                        w_resp_done = 1'b1;
                        w_state     = S_IDLE;
                    end else if (r_cnt == 6'd0) begin
                        w_out  = 1'b1;
                        w_tail = 1'b1;
                    end else begin
                        w_cnt  = r_cnt - 6'd1;
                        w_out  = r_resp[FRAME_LEN-2];
                        w_resp = {r_resp[FRAME_LEN-2:0], 1'b0};
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_crc        <= '0;
            r_shift      <= '0;
            r_resp       <= '0;
            r_wait       <= '0;
            r_fin        <= 1'b0;
            r_oe         <= 1'b0;
            r_out        <= 1'b1;
            r_tail       <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_cmd_idx    <= '0;
            r_cmd_arg    <= '0;
            r_cmd_crcerr <= 1'b0;
            r_busy       <= 1'b0;
            r_resp_done  <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_cnt        <= w_cnt;
            r_crc        <= w_crc;
            r_shift      <= w_shift;
            r_resp       <= w_resp;
            r_wait       <= w_wait;
            r_fin        <= w_fin;
            r_oe         <= w_oe;
            r_out        <= w_out;
            r_tail       <= w_tail;
            r_cmd_valid  <= w_cmd_valid;
            r_cmd_idx    <= w_cmd_idx;
            r_cmd_arg    <= w_cmd_arg;
            r_cmd_crcerr <= w_cmd_crcerr;
            r_busy       <= (w_state != S_IDLE);
            r_resp_done  <= w_resp_done;
        end
    end

    assign cmd_valid  = r_cmd_valid;
    assign cmd_idx    = r_cmd_idx;
    assign cmd_arg    = r_cmd_arg;
    assign cmd_crcerr = r_cmd_crcerr;
    assign busy       = r_busy;
    assign resp_done  = r_resp_done;

endmodule

// File: tb/tb_sdcmd_card.sv
// Bench for sdcmd_card: a host model drives command frames, a frame/CRC model predicts results.
module tb_sdcmd_card;

    localparam int unsigned NCR = 2;

    logic        clk   = 1'b0;
    logic        sdclk = 1'b0;
    logic        rst   = 1'b1;
    logic        host_oe  = 1'b0;
    logic        host_bit = 1'b1;
    logic        resp_start = 1'b0;
    logic        resp_drop  = 1'b0;
    logic [5:0]  resp_cmd   = 6'd0;
    logic [31:0] resp_arg   = 32'd0;
    logic        resp_nocrc = 1'b0;
    logic        cmd_valid;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    logic        cmd_crcerr;
    logic        busy;
    logic        resp_done;

    wire sdcmd;
    pullup (sdcmd);
    assign sdcmd = host_oe ? host_bit : 1'bz;

    int          checks   = 0;
    int          failures = 0;
    logic        line_quiet = 1'b1;
    logic [47:0] exp_q[$];
    logic [47:0] cmp_f;

    always #5  clk   = ~clk;
    always #40 sdclk = ~sdclk;

    sdcmd_card #(.NCR(NCR), .WAIT_EDGES(64), .SYNC(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .sdclk      (sdclk),
        .sdcmd      (sdcmd),
        .cmd_valid  (cmd_valid),
        .cmd_idx    (cmd_idx),
        .cmd_arg    (cmd_arg),
        .cmd_crcerr (cmd_crcerr),
        .busy       (busy),
        .resp_start (resp_start),
        .resp_drop  (resp_drop),
        .resp_cmd   (resp_cmd),
        .resp_arg   (resp_arg),
        .resp_nocrc (resp_nocrc),
        .resp_done  (resp_done)
    );

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Remainder of msg * x^7 divided by x^7 + x^3 + 1, by long division.
    function automatic logic [6:0] model_crc7(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] msg;
        msg = {2'b01, idx, arg};
        return {msg, model_crc7(msg), 1'b1};
    endfunction

    function automatic logic [47:0] resp_frame(input logic [5:0] idx, input logic [31:0] arg,
                                               input logic nocrc);
        logic [39:0] msg;
        if (nocrc) return {2'b00, 6'h3F, arg, 7'h7F, 1'b1};
        msg = {2'b00, idx, arg};
        return {msg, model_crc7(msg), 1'b1};
    endfunction

    function automatic logic model_crcerr(input logic [47:0] f);
        return (model_crc7(f[47:8]) != f[7:1]) || !f[0] || !f[46] || f[47];
    endfunction

    // Compare process: every received frame and every cycle the line should be idle.
    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_cmd_valid", 48'(cmd_valid), 48'(0));
                end else begin
                    cmp_f = exp_q.pop_front();
                    check("cmd_idx",    48'(cmd_idx),    48'(cmp_f[45:40]));
                    check("cmd_arg",    48'(cmd_arg),    48'(cmp_f[39:8]));
                    check("cmd_crcerr", 48'(cmd_crcerr), 48'(model_crcerr(cmp_f)));
                    check("busy_on_valid", 48'(busy), 48'(1));
                end
            end
            if (line_quiet && !host_oe) check("line_released", 48'(sdcmd), 48'(1));
        end
    end

    task automatic send_frame(input logic [47:0] f);
        exp_q.push_back(f);
        for (int i = 47; i >= 0; i--) begin
            @(negedge sdclk);
            host_oe  = 1'b1;
            host_bit = f[i];
        end
        @(posedge sdclk);
        fork
            begin
                @(negedge sdclk);
                host_oe  = 1'b0;
                host_bit = 1'b1;
            end
        join_none
    endtask

    task automatic wait_valid();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("cmd_valid_timeout", 48'(0), 48'(1));
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (resp_done) begin
                ok = 1;
                break;
            end
        end
        check("resp_done_seen", 48'(ok), 48'(1));
        check("busy_after_done", 48'(busy), 48'(0));
    endtask

    task automatic capture(output logic [47:0] f, output int dly);
        bit found = 0;
        dly = 0;
        f   = '1;
        for (int k = 1; k <= 150; k++) begin
            @(posedge sdclk);
            if (sdcmd == 1'b0) begin
                dly   = k;
                found = 1;
                break;
            end
        end
        if (!found) begin
            check("resp_start_timeout", 48'(0), 48'(1));
            return;
        end
        f[47] = 1'b0;
        for (int b = 46; b >= 0; b--) begin
            @(posedge sdclk);
            f[b] = sdcmd;
        end
    endtask

    task automatic pulse_start(input logic [5:0] idx, input logic [31:0] arg, input logic nocrc);
        resp_cmd   = idx;
        resp_arg   = arg;
        resp_nocrc = nocrc;
        resp_start = 1'b1;
        @(negedge clk);
        resp_start = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] f;
        int          dly;
        bit          found;

        repeat (5) @(negedge clk);
        check("rst_cmd_valid",  48'(cmd_valid),  48'(0));
        check("rst_cmd_idx",    48'(cmd_idx),    48'(0));
        check("rst_cmd_arg",    48'(cmd_arg),    48'(0));
        check("rst_cmd_crcerr", 48'(cmd_crcerr), 48'(0));
        check("rst_busy",       48'(busy),       48'(0));
        check("rst_resp_done",  48'(resp_done),  48'(0));
        check("rst_line",       48'(sdcmd),      48'(1));
        rst = 1'b0;

        // Pin the model against well-known frames.
        check("model_crc_cmd0",  48'(model_crc7(40'h4000000000)), 48'(7'h4A));
        check("model_crc_cmd8",  48'(model_crc7(40'h48000001AA)), 48'(7'h43));
        check("model_frame_cmd0", cmd_frame(6'd0, 32'h0),   48'h400000000095);
        check("model_frame_cmd8", cmd_frame(6'd8, 32'h1AA), 48'h48000001AA87);
        check("model_resp_r7",    resp_frame(6'd8, 32'h1AA, 1'b0), 48'h08000001AA13);

        // resp_start while idle must not wake the block.
        @(negedge clk);
        pulse_start(6'd8, 32'h1AA, 1'b0);
        repeat (3) @(negedge clk);
        check("idle_start_ignored", 48'(busy), 48'(0));

        // CMD0, then drop.
        send_frame(48'h400000000095);
        wait_valid();
        check("cmd0_idx_lit", 48'(cmd_idx), 48'(0));
        resp_drop = 1'b1;
        @(negedge clk);
        resp_drop = 1'b0;
        @(negedge clk);
        check("cmd0_drop_busy", 48'(busy), 48'(0));
        repeat (10) @(posedge sdclk);

        // Drop wins when it coincides with start.
        send_frame(48'h400000000095);
        wait_valid();
        resp_start = 1'b1;
        resp_drop  = 1'b1;
        @(negedge clk);
        resp_start = 1'b0;
        resp_drop  = 1'b0;
        @(negedge clk);
        check("drop_priority_busy", 48'(busy), 48'(0));
        repeat (10) @(posedge sdclk);

        // CMD8 with an R7 response.
        send_frame(48'h48000001AA87);
        wait_valid();
        check("cmd8_arg_lit", 48'(cmd_arg), 48'(32'h1AA));
        line_quiet = 1'b0;
        pulse_start(6'd8, 32'h1AA, 1'b0);
        capture(f, dly);
        check("r7_ncr_delay", 48'(dly), 48'(NCR));
        check("r7_frame_lit", f, 48'h08000001AA13);
        check("r7_frame_model", f, resp_frame(6'd8, 32'h1AA, 1'b0));
        wait_done();
        line_quiet = 1'b1;

        // CMD55 with a bad CRC, then let the wait time out.
        send_frame(48'h770000000064);
        wait_valid();
        check("cmd55_crcerr_lit", 48'(cmd_crcerr), 48'(1));
        repeat (63) @(posedge sdclk);
        #40;
        check("wait_busy_63", 48'(busy), 48'(1));
        @(posedge sdclk);
        #50;
        check("wait_busy_64", 48'(busy), 48'(0));

        // ACMD41 with an R3 response.
        send_frame(cmd_frame(6'd41, 32'h40FF8000));
        wait_valid();
        check("acmd41_idx_lit", 48'(cmd_idx), 48'(41));
        line_quiet = 1'b0;
        pulse_start(6'd41, 32'h80FF8000, 1'b1);
        capture(f, dly);
        check("r3_ncr_delay", 48'(dly), 48'(NCR));
        check("r3_frame_lit", f, 48'h3F80FF8000FF);
        check("r3_frame_model", f, resp_frame(6'd41, 32'h80FF8000, 1'b1));
        wait_done();
        line_quiet = 1'b1;
        resp_nocrc = 1'b0;

        // Reset in the middle of a response.
        send_frame(48'h48000001AA87);
        wait_valid();
        line_quiet = 1'b0;
        pulse_start(6'd8, 32'h1AA, 1'b0);
        found = 0;
        for (int k = 0; k < 150; k++) begin
            @(posedge sdclk);
            if (sdcmd == 1'b0) begin
                found = 1;
                break;
            end
        end
        check("rstmid_start_seen", 48'(found), 48'(1));
        repeat (12) @(posedge sdclk);
        @(negedge clk);
        check("rstmid_driving_zero", 48'(sdcmd), 48'(0));
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_released", 48'(sdcmd), 48'(1));
        check("rstmid_busy", 48'(busy), 48'(0));
        rst = 1'b0;
        line_quiet = 1'b1;
        repeat (4) @(posedge sdclk);

        send_frame(48'h400000000095);
        wait_valid();
        check("post_rst_cmd0_idx", 48'(cmd_idx), 48'(0));
        check("post_rst_cmd0_crcerr", 48'(cmd_crcerr), 48'(0));
        resp_drop = 1'b1;
        @(negedge clk);
        resp_drop = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 48'(busy), 48'(0));
        repeat (4) @(posedge sdclk);
        check("exp_queue_empty", 48'(exp_q.size()), 48'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
